// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: bundle of the two client command/response channels and
// the single-port RAM bus.
//   slave  : arbiter view (takes client commands and ram_dout, drives grants,
//            read responses and the RAM command port)
//   master : environment view (clients plus RAM core)
interface ram_arbiter_if #(
   parameter int AW = 8,
   parameter int DW = 10
);
   logic          req0, req1;
   logic          we0, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          gnt0, gnt1;
   logic          rvalid0, rvalid1;
   logic [DW-1:0] rdata0, rdata1;
   logic          ram_en, ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_dout,
      output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
             ram_en, ram_we, ram_addr, ram_din
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_dout,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
             ram_en, ram_we, ram_addr, ram_din
   );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-client round-robin arbiter/sequencer in front of a
// single-port RAM with registered read data.
// Ports:
//   clk    rising-edge clock shared with the RAM core
//   rst_n  asynchronous active-low reset
//   bus    ram_arbiter_if.slave: client req/we/addr/wdata in, gnt/rvalid/
//          rdata out, ram_en/ram_we/ram_addr/ram_din out, ram_dout in
// Sequence per command: IDLE (sample + register) -> ACCESS (RAM port driven,
// gnt high) -> [reads only] RESP (capture ram_dout) -> IDLE. All outputs are
// registered.
module ram_arbiter #(
   parameter int AW = 8,
   parameter int DW = 10
) (
   input logic           clk,
   input logic           rst_n,
   ram_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t              state, state_d;
   logic                ptr, ptr_d;       // round-robin priority pointer
   logic                owner, owner_d;   // client of the command in flight
   logic                win;
   logic                en_q, en_d, we_q, we_d;
   logic [AW-1:0]       addr_q, addr_d;
   logic [DW-1:0]       din_q, din_d;
   logic [1:0]          gnt_q, gnt_d;
   logic [1:0]          rvalid_q, rvalid_d;
   logic [1:0][DW-1:0]  rdata_q, rdata_d;

   always_comb begin
      state_d  = state;
      ptr_d    = ptr;
      owner_d  = owner;
      en_d     = 1'b0;
      we_d     = 1'b0;
      addr_d   = addr_q;
      din_d    = din_q;
      gnt_d    = '0;
      rvalid_d = '0;
      rdata_d  = rdata_q;
      // sole requester wins; on a tie the pointer decides
      win      = (bus.req0 & bus.req1) ? ptr : bus.req1;
      case (state)
         IDLE: if (bus.req0 | bus.req1) begin
            state_d    = ACCESS;
            en_d       = 1'b1;
            we_d       = win ? bus.we1    : bus.we0;
            addr_d     = win ? bus.addr1  : bus.addr0;
            din_d      = win ? bus.wdata1 : bus.wdata0;
            gnt_d[win] = 1'b1;
            owner_d    = win;
            ptr_d      = ~win;
         end
         // RAM samples the command at the edge ending this state
         ACCESS: state_d = we_q ? IDLE : RESP;
         RESP: begin
            state_d         = IDLE;
            rvalid_d[owner] = 1'b1;
            rdata_d[owner]  = bus.ram_dout;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ptr      <= 1'b0;
         owner    <= 1'b0;
         en_q     <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         din_q    <= '0;
         gnt_q    <= '0;
         rvalid_q <= '0;
         rdata_q  <= '0;
      end else begin
         state    <= state_d;
         ptr      <= ptr_d;
         owner    <= owner_d;
         en_q     <= en_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         din_q    <= din_d;
         gnt_q    <= gnt_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
      end
   end

   assign bus.ram_en   = en_q;
   assign bus.ram_we   = we_q;
   assign bus.ram_addr = addr_q;
   assign bus.ram_din  = din_q;
   assign bus.gnt0     = gnt_q[0];
   assign bus.gnt1     = gnt_q[1];
   assign bus.rvalid0  = rvalid_q[0];
   assign bus.rvalid1  = rvalid_q[1];
   assign bus.rdata0   = rdata_q[0];
   assign bus.rdata1   = rdata_q[1];
endmodule
